// File: rtl/module_decodificador_secded.sv
// module_decodificador_secded: two-stage pipelined SECDED decoder with valid/ready handshake.
// Optional build macro SECDED_ERR_CNT_EN adds saturating single/double error counters.
module module_decodificador_secded #(
    parameter int DATA_W = 4,
    parameter int PAR_W  = 3,
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] datos_cod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] datos_out,
    output logic              err_single,
    output logic              err_double,
    output logic [PAR_W-1:0]  sindrome
`ifdef SECDED_ERR_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [15:0]       cnt_single,
    output logic [15:0]       cnt_double
`endif
);

    if (DATA_W < 1) begin : g_data_chk
        $error("DATA_W must be at least 1");
    end
    if (2**PAR_W < CODE_W) begin : g_par_chk
        $error("PAR_W too small to address every code word position");
    end

    // Hamming position of data bit j: the j-th non-power-of-two position.
    function automatic int dpos(input int j);
        int n;
        n = 0;
        dpos = 0;
        for (int p = 1; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == j) dpos = p;
                n++;
            end
        end
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_dat_q, s1_dat_d;
    logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
    logic              s1_glb_q, s1_glb_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              sng_q, sng_d;
    logic              dbl_q, dbl_d;
    logic [PAR_W-1:0]  syn_q, syn_d;
    logic              stall, s_nz, s_bad, fix;

    assign stall      = out_valid_q && !out_ready;
    assign in_ready   = !stall;
    assign out_valid  = out_valid_q;
    assign datos_out  = dat_q;
    assign err_single = sng_q;
    assign err_double = dbl_q;
    assign sindrome   = syn_q;
    assign s_nz       = |s1_syn_q;
    assign s_bad      = int'(s1_syn_q) > CODE_W - 1;
    assign fix        = s1_glb_q && s_nz && !s_bad;

    // Stage 1: syndrome, global check and raw data bits of an accepted word.
    always_comb begin
        s1_valid_d = stall ? s1_valid_q : in_valid;
        s1_dat_d   = s1_dat_q;
        s1_syn_d   = s1_syn_q;
        s1_glb_d   = s1_glb_q;
        if (in_valid && in_ready) begin
            s1_glb_d = ^datos_cod;
            s1_syn_d = '0;
            for (int p = 1; p < CODE_W; p++)
                for (int k = 0; k < PAR_W; k++)
                    if (((p >> k) & 1) != 0) s1_syn_d[k] = s1_syn_d[k] ^ datos_cod[p-1];
            for (int j = 0; j < DATA_W; j++) s1_dat_d[j] = datos_cod[dpos(j)-1];
        end
    end

    // Stage 2: classify and correct; results are held while no new word arrives.
    always_comb begin
        out_valid_d = stall ? out_valid_q : s1_valid_q;
        dat_d       = dat_q;
        sng_d       = sng_q;
        dbl_d       = dbl_q;
        syn_d       = syn_q;
        if (!stall && s1_valid_q) begin
            syn_d = s1_syn_q;
            sng_d = s1_glb_q && (!s_nz || !s_bad);
            dbl_d = s_nz && (!s1_glb_q || s_bad);
            for (int j = 0; j < DATA_W; j++)
                dat_d[j] = s1_dat_q[j] ^ (fix && dpos(j) == int'(s1_syn_q));
        end
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_dat_q    <= '0;
            s1_syn_q    <= '0;
            s1_glb_q    <= 1'b0;
            out_valid_q <= 1'b0;
            dat_q       <= '0;
            sng_q       <= 1'b0;
            dbl_q       <= 1'b0;
            syn_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_dat_q    <= s1_dat_d;
            s1_syn_q    <= s1_syn_d;
            s1_glb_q    <= s1_glb_d;
            out_valid_q <= out_valid_d;
            dat_q       <= dat_d;
            sng_q       <= sng_d;
            dbl_q       <= dbl_d;
            syn_q       <= syn_d;
        end
    end

`ifdef SECDED_ERR_CNT_EN
    logic [15:0] cnt_single_q, cnt_single_d, cnt_double_q, cnt_double_d;
    logic        xfer;

    assign xfer       = out_valid_q && out_ready;
    assign cnt_single = cnt_single_q;
    assign cnt_double = cnt_double_q;

    // Saturating counters of transferred flagged words; clear wins over increment.
    always_comb begin
        cnt_single_d = cnt_clr ? 16'd0 :
                       (xfer && sng_q && cnt_single_q != 16'hFFFF) ? cnt_single_q + 16'd1 : cnt_single_q;
        cnt_double_d = cnt_clr ? 16'd0 :
                       (xfer && dbl_q && cnt_double_q != 16'hFFFF) ? cnt_double_q + 16'd1 : cnt_double_q;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_single_q <= 16'd0;
            cnt_double_q <= 16'd0;
        end else begin
            cnt_single_q <= cnt_single_d;
            cnt_double_q <= cnt_double_d;
        end
    end
`endif

endmodule

// File: tb/tb_module_decodificador_secded.sv
// tb_module_decodificador_secded: scoreboard bench for the SECDED decoder (DATA_W=4, PAR_W=3).
module tb_module_decodificador_secded;

    typedef struct packed {
        logic [3:0] dat;
        logic       sng;
        logic       dbl;
        logic [2:0] syn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] datos_cod = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] datos_out;
    logic       err_single;
    logic       err_double;
    logic [2:0] sindrome;
`ifdef SECDED_ERR_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] cnt_single;
    logic [15:0] cnt_double;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [7:0] words[$];
    logic       hold_ok = 1'b0;
    exp_t       hold;
    logic       saw_stall = 1'b0;

    module_decodificador_secded #(.DATA_W(4), .PAR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .datos_cod(datos_cod), .out_valid(out_valid), .out_ready(out_ready),
        .datos_out(datos_out), .err_single(err_single), .err_double(err_double),
        .sindrome(sindrome)
`ifdef SECDED_ERR_CNT_EN
        , .cnt_clr(cnt_clr), .cnt_single(cnt_single), .cnt_double(cnt_double)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: syndrome as XOR of the positions of set bits, fixed data bit positions 3,5,6,7.
    function automatic exp_t model(input logic [7:0] cw);
        exp_t e;
        logic [7:0] fx;
        logic g;
        e.syn = 3'd0;
        g = ^cw;
        for (int p = 1; p < 8; p++) if (cw[p-1]) e.syn = e.syn ^ 3'(p);
        e.sng = g;
        e.dbl = !g && (e.syn != 3'd0);
        fx = cw;
        if (g && e.syn != 3'd0) fx[e.syn-1] = ~fx[e.syn-1];
        e.dat = {fx[6], fx[5], fx[4], fx[2]};
        return e;
    endfunction

    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0] c;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[7] = ^c[6:0];
        return c;
    endfunction

    // Monitor: checks stall stability, pops expected results on transfer, pushes on accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_ok = 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                if (hold_ok) chk("stall_hold", {datos_out, err_single, err_double, sindrome}, hold);
                hold = {datos_out, err_single, err_double, sindrome};
                hold_ok = 1'b1;
            end else begin
                hold_ok = 1'b0;
            end
            if (out_valid) chk("flag_excl", 32'(err_single & err_double), 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("datos_out", 32'(datos_out), 32'(e.dat));
                    chk("err_single", 32'(err_single), 32'(e.sng));
                    chk("err_double", 32'(err_double), 32'(e.dbl));
                    chk("sindrome", 32'(sindrome), 32'(e.syn));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(datos_cod));
        end
    end

    // Drives the word list; mode 0 always ready, 1 stall cycles 3..6, 2 random backpressure.
    task automatic run(input int mode);
        int idx = 0;
        int cyc = 0;
        logic acc;
        while ((idx < words.size() || sb.size() > 0) && cyc < 2000) begin
            in_valid  = idx < words.size();
            datos_cod = in_valid ? words[idx] : 8'($urandom);
            out_ready = mode == 0 ? 1'b1 :
                        mode == 1 ? !(cyc >= 3 && cyc <= 6) :
                        ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (!in_ready) saw_stall = 1'b1;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        if (cyc >= 2000) chk("timeout", 32'(sb.size() + words.size() - idx), 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_flags", {29'd0, err_single, err_double, 1'b0}, 0);
        chk("rst_sindrome", 32'(sindrome), 0);
        @(posedge clk);
        #1;
        words = '{8'h55, 8'h45, 8'hD5, 8'h44};
        run(0);
`ifdef SECDED_ERR_CNT_EN
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
`endif
        saw_stall = 1'b0;
        words = '{8'h55, 8'h45, 8'h44};
        run(1);
        chk("bp_in_ready_drop", 32'(saw_stall), 1);
`ifdef SECDED_ERR_CNT_EN
        chk("cnt_single", 32'(cnt_single), 1);
        chk("cnt_double", 32'(cnt_double), 1);
`endif
        words.delete();
        for (int i = 0; i < 200; i++) begin
            logic [7:0] cw;
            int a, b;
            cw = enc(4'($urandom_range(0, 15)));
            a = $urandom_range(0, 7);
            b = (a + $urandom_range(1, 7)) % 8;
            case ($urandom_range(0, 2))
                1: cw[a] = ~cw[a];
                2: begin cw[a] = ~cw[a]; cw[b] = ~cw[b]; end
                default: ;
            endcase
            words.push_back(cw);
        end
        run(2);
        in_valid  = 1'b1;
        datos_cod = 8'h55;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        datos_cod = 8'h45;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_cycle2", 32'(out_valid), 1);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
